// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequences an ECP5 PLL, qualifies LOCK and releases per-domain resets in order.
// Rev 1.0
`default_nettype none

module pll_lock_supervisor #(
  parameter int CHANNELS       = 3,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_FILTER    = 1024,
  parameter int LOCK_TIMEOUT   = 1048576,
  parameter int STAGGER        = 256,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                clkin,
  input  logic                rst,
  input  logic                pll_locked,
  input  logic                force_relock,
  input  logic                clear_fault,
  output logic                pll_rst,
  output logic [CHANNELS-1:0] chan_rst,
  output logic [CHANNELS-1:0] chan_ready,
  output logic [2:0]          state,
  output logic [1:0]          retry_count,
  output logic [7:0]          lock_loss_count,
  output logic                fault
);

  localparam int RW = $clog2(PLL_RST_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int FW = $clog2(LOCK_FILTER + 1);
  localparam int SW = $clog2((CHANNELS - 1) * STAGGER + 2);

  localparam logic [RW-1:0] RST_LAST  = RW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILTER - 1);
  localparam logic [SW-1:0] STG_LAST  = SW'((CHANNELS - 1) * STAGGER);
  localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_RELEASE   = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  state_t cur, nxt;
  logic sync1, lk_s;
  logic [RW-1:0] rst_cnt, rst_cnt_n;
  logic [TW-1:0] to_cnt, to_cnt_n;
  logic [FW-1:0] filt_cnt, filt_cnt_n;
  logic [SW-1:0] stg_cnt, stg_cnt_n;
  logic pll_rst_n, fault_n, restart, lost;
  logic [CHANNELS-1:0] chan_rst_n, chan_ready_n;
  logic [1:0] retry_n, retry_inc;
  logic [7:0] llc_n;

  assign state = cur;

  always_ff @(posedge clkin) begin
    if (rst) begin
      sync1           <= 1'b0;
      lk_s            <= 1'b0;
      cur             <= S_RESET_PLL;
      rst_cnt         <= '0;
      to_cnt          <= '0;
      filt_cnt        <= '0;
      stg_cnt         <= '0;
      pll_rst         <= 1'b1;
      chan_rst        <= '1;
      chan_ready      <= '0;
      retry_count     <= 2'd0;
      lock_loss_count <= 8'd0;
      fault           <= 1'b0;
    end else begin
      sync1           <= pll_locked;
      lk_s            <= sync1;
      cur             <= nxt;
      rst_cnt         <= rst_cnt_n;
      to_cnt          <= to_cnt_n;
      filt_cnt        <= filt_cnt_n;
      stg_cnt         <= stg_cnt_n;
      pll_rst         <= pll_rst_n;
      chan_rst        <= chan_rst_n;
      chan_ready      <= chan_ready_n;
      retry_count     <= retry_n;
      lock_loss_count <= llc_n;
      fault           <= fault_n;
    end
  end

  always_comb begin
    nxt          = cur;
    rst_cnt_n    = rst_cnt;
    to_cnt_n     = to_cnt;
    filt_cnt_n   = filt_cnt;
    stg_cnt_n    = stg_cnt;
    pll_rst_n    = pll_rst;
    chan_rst_n   = chan_rst;
    chan_ready_n = chan_ready;
    retry_n      = retry_count;
    llc_n        = lock_loss_count;
    fault_n      = fault;
    retry_inc    = retry_count + 2'd1;
    restart      = 1'b0;
    // A single unlocked synchronised sample is treated as a loss; no filtering here.
    lost         = ((cur == S_RELEASE) || (cur == S_RUN)) && !lk_s;

    if (force_relock && (cur != S_FAULT)) begin
      restart = 1'b1;
    end else if (lost) begin
      restart = 1'b1;
      retry_n = 2'd0;
      llc_n   = (lock_loss_count == 8'hFF) ? lock_loss_count : lock_loss_count + 8'd1;
    end else begin
      unique case (cur)
        S_RESET_PLL: begin
          if (rst_cnt == RST_LAST) begin
            nxt       = S_WAIT_LOCK;
            pll_rst_n = 1'b0;
          end else begin
            rst_cnt_n = rst_cnt + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (lk_s && (filt_cnt == FILT_LAST)) begin
            nxt = S_RELEASE;
          end else if (to_cnt == TO_LAST) begin
            retry_n = retry_inc;
            if (retry_inc == RETRY_MAX) begin
              nxt       = S_FAULT;
              pll_rst_n = 1'b1;
              fault_n   = 1'b1;
            end else begin
              restart = 1'b1;
            end
          end else begin
            to_cnt_n   = to_cnt + 1'b1;
            filt_cnt_n = lk_s ? filt_cnt + 1'b1 : '0;
          end
        end
        S_RELEASE: begin
          for (int i = 0; i < CHANNELS; i++) begin
            if (stg_cnt == SW'(i * STAGGER)) begin
              chan_rst_n[i]   = 1'b0;
              chan_ready_n[i] = 1'b1;
            end
          end
          if (stg_cnt == STG_LAST) begin
            nxt     = S_RUN;
            retry_n = 2'd0;
          end else begin
            stg_cnt_n = stg_cnt + 1'b1;
          end
        end
        S_RUN: begin
          chan_rst_n   = '0;
          chan_ready_n = '1;
        end
        S_FAULT: begin
          if (clear_fault) begin
            restart = 1'b1;
            retry_n = 2'd0;
          end
        end
        default: restart = 1'b1;
      endcase
    end

    if (restart) begin
      nxt          = S_RESET_PLL;
      rst_cnt_n    = '0;
      to_cnt_n     = '0;
      filt_cnt_n   = '0;
      stg_cnt_n    = '0;
      pll_rst_n    = 1'b1;
      chan_rst_n   = '1;
      chan_ready_n = '0;
      fault_n      = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Parametrised successor to the fixed single-PLL clock wrapper: sequences and supervises an ECP5 EHXPLLL instance.
- Drives the PLL RST pin and qualifies LOCK with a glitch filter and a timeout with bounded retry.
- Releases CHANNELS per-domain resets in staggered order; detects lock loss and re-acquires automatically.
- Runs on the PLL reference clock, instantiated beside the PLL in each board top.

Parameters:
CHANNELS, 3, number of downstream clock domains (1..8), one reset/ready pair each
PLL_RST_CYCLES, 16, cycles pll_rst is held high per acquisition attempt (>=1)
LOCK_FILTER, 1024, consecutive synchronised-locked cycles required to accept lock (>=1)
LOCK_TIMEOUT, 1048576, cycles allowed in WAIT_LOCK before an attempt fails (> LOCK_FILTER)
STAGGER, 256, cycles between successive channel reset releases (>=1)
MAX_RETRIES, 3, failed attempts tolerated before FAULT (>=1)

Ports:
clkin  in  1  reference clock (25 MHz on ULX3S); sole clock
rst  in  1  synchronous, active-high reset
pll_locked  in  1  raw PLL LOCK, asynchronous to clkin
force_relock  in  1  one-cycle pulse: restart acquisition
clear_fault  in  1  one-cycle pulse: leave FAULT
pll_rst  out  1  to PLL RST, active-high
chan_rst  out  CHANNELS  per-domain reset, active-high, bit i = channel i
chan_ready  out  CHANNELS  bit i high once channel i released and lock held
state  out  3  0=RESET_PLL 1=WAIT_LOCK 2=RELEASE 3=RUN 4=FAULT
retry_count  out  2  failed attempts in current sequence
lock_loss_count  out  8  lock losses seen in RUN/RELEASE, saturates at 255
fault  out  1  high in FAULT

Behaviour:
- One clock domain; reset is synchronous and active-high.
- All outputs registered. Reset values: pll_rst=1, chan_rst=all 1, chan_ready=0, state=0, retry_count=0, lock_loss_count=0, fault=0.
- pll_locked passes a 2-FF synchroniser (lk_s). A change at edge n is visible to the FSM at edge n+2. The synchroniser resets to 0.
- RESET_PLL:
  - pll_rst=1, chan_rst all 1, chan_ready all 0.
  - Counts PLL_RST_CYCLES cycles, then goes to WAIT_LOCK.
- WAIT_LOCK:
  - pll_rst=0. Timeout counter starts at 0 on entry. Filter counter increments while lk_s=1 and clears to 0 when lk_s=0.
  - When the filter reaches LOCK_FILTER, go to RELEASE.
  - Otherwise, when the timeout reaches LOCK_TIMEOUT-1, increment retry_count. If the new value equals MAX_RETRIES, go to FAULT; else go to RESET_PLL.
  - If both events fall on the same cycle, lock wins.
- RELEASE:
  - Stagger counter starts at 0 on entry.
  - chan_rst[i] clears, and chan_ready[i] sets, on the edge where the counter equals i*STAGGER. Channel 0 is released on the first RELEASE cycle.
  - After channel CHANNELS-1 is released, go to RUN and clear retry_count.
- RUN: holds chan_rst all 0 and chan_ready all 1.
- Lock loss, in RELEASE or RUN: lk_s=0 for a single cycle means loss.
  - Next edge: chan_rst all 1, chan_ready all 0, lock_loss_count+1 (saturating), retry_count=0, state=RESET_PLL.
  - No filtering on loss.
- FAULT:
  - pll_rst=1, chan_rst all 1, fault=1. Ignores pll_locked and force_relock.
  - clear_fault: next edge goes to RESET_PLL with retry_count=0 and fault=0.
- force_relock outside FAULT: next edge goes to RESET_PLL with retry_count unchanged and all counters cleared.
  - It is not a lock loss; lock_loss_count is not incremented.
- Priority: rst > force_relock > clear_fault > lock-loss/timeout > normal progression.
- rst mid-sequence returns all outputs to reset values on the next edge, including lock_loss_count.
- Counter widths are sized with $clog2 of their parameter. There is no wrap: each counter stops at its terminal value.

Test Plan:
All scenarios use CHANNELS=3, PLL_RST_CYCLES=4, LOCK_FILTER=8, LOCK_TIMEOUT=64, STAGGER=4, MAX_RETRIES=2.
1. Clean lock:
   - Stimulus: deassert rst at edge 0; pll_locked=1 from edge 0.
   - Required: pll_rst high on edges 1-4. WAIT_LOCK from edge 5. State 2 about 8 cycles after lk_s rises. chan_rst bits clear at 0/+4/+8 cycles into RELEASE. State 3 follows. retry_count=0.
2. Glitch filter:
   - Stimulus: pll_locked high 7 cycles, low 1, then high.
   - Required: no RELEASE until 8 further consecutive synchronised-high cycles.
3. Timeout and fault:
   - Stimulus: pll_locked held 0.
   - Required: retry_count=1 after the first 64 WAIT_LOCK cycles, then a second RESET_PLL. FAULT with retry_count=2, fault=1, pll_rst=1. A clear_fault pulse returns to state 0 with fault=0.
4. Lock loss in RUN:
   - Stimulus: drop pll_locked for 1 cycle.
   - Required: chan_rst=3'b111 and chan_ready=0 two edges after the drop plus one. lock_loss_count=1. Re-acquisition completes to RUN.
5. Loss mid-RELEASE:
   - Stimulus: drop lock after channel 0 is released.
   - Required: channels 1-2 never released. All chan_rst re-asserted. lock_loss_count increments.
6. force_relock and rst:
   - Stimulus: force_relock in RUN; separately, rst asserted in WAIT_LOCK.
   - Required: force_relock gives state 0 next edge with lock_loss_count unchanged. rst returns all outputs to their reset values.
